// File: rtl/program_memory_if.sv
// program_memory_if: fetch and load bus of the banked program memory.
// master = CPU/loader side, slave = program_memory.
// PROGMEM_PARITY_EN adds the parityError return signal.
interface program_memory_if #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_BANKS   = 4
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    // fetch side
    logic [BANK_W-1:0]      programSelect;
    logic                   fetchValid;
    logic [ADDR_WIDTH-1:0]  fetchAddress;
    logic                   instrValid;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   endOfProgram;
    logic [ADDR_WIDTH:0]    bankLength;

    // load side
    logic                   loadStart;
    logic [BANK_W-1:0]      loadBank;
    logic                   loadValid;
    logic [INSTR_WIDTH-1:0] loadData;
    logic                   loadLast;
    logic                   loadReady;
    logic                   loadDone;
    logic                   loadOverflow;
`ifdef PROGMEM_PARITY_EN
    logic                   parityError;
`endif

    modport master (
        output programSelect, fetchValid, fetchAddress,
        output loadStart, loadBank, loadValid, loadData, loadLast,
        input  instrValid, instruction, endOfProgram, bankLength,
        input  loadReady, loadDone, loadOverflow
`ifdef PROGMEM_PARITY_EN
        , input parityError
`endif
    );

    modport slave (
        input  programSelect, fetchValid, fetchAddress,
        input  loadStart, loadBank, loadValid, loadData, loadLast,
        output instrValid, instruction, endOfProgram, bankLength,
        output loadReady, loadDone, loadOverflow
`ifdef PROGMEM_PARITY_EN
        , output parityError
`endif
    );
endinterface

// File: rtl/program_memory.sv
// program_memory: writable multi-bank instruction memory.
// Programs are streamed into one bank over a valid/ready load port while the
// CPU fetches (1-cycle registered read) from the bank chosen by programSelect.
// Addresses at or past a bank's loaded length return HALT_WORD.
// Optional feature macro: PROGMEM_PARITY_EN (even parity bit per stored word).
module program_memory #(
    parameter int                     INSTR_WIDTH = 16,
    parameter int                     ADDR_WIDTH  = 8,
    parameter int                     NUM_BANKS   = 4,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = 16'hE000
) (
    input  logic               clk,
    input  logic               rst_n,
    program_memory_if.slave    bus
);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
`ifdef PROGMEM_PARITY_EN
    localparam int MEM_W  = INSTR_WIDTH + 1;
`else
    localparam int MEM_W  = INSTR_WIDTH;
`endif
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX  = '1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_FULL = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOADING, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [BANK_W-1:0]       cur_bank_q, cur_bank_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]     len_q [NUM_BANKS];
    logic [ADDR_WIDTH:0]     len_d [NUM_BANKS];
    logic                    overflow_q, overflow_d;

    logic                    instr_valid_q, instr_valid_d;
    logic [INSTR_WIDTH-1:0]  instruction_q, instruction_d;
    logic                    eop_q, eop_d;
`ifdef PROGMEM_PARITY_EN
    logic                    perr_q, perr_d;
`endif

    // Flat storage: index = {bank, address}. Contents are never reset.
    logic [MEM_W-1:0]               mem [NUM_BANKS*DEPTH];
    logic                           wr_en;
    logic [BANK_W+ADDR_WIDTH-1:0]   wr_idx;
    logic [MEM_W-1:0]               wr_word;

    logic                    load_ready;
    logic                    load_done;
    logic                    beat;
    logic                    sel_ok;
    logic [ADDR_WIDTH:0]     sel_len;
    logic                    hit;
    logic [MEM_W-1:0]        rd_word;

    function automatic logic bank_ok(input logic [BANK_W-1:0] b);
        return int'(b) < NUM_BANKS;
    endfunction

    function automatic logic [MEM_W-1:0] encode(input logic [INSTR_WIDTH-1:0] d);
`ifdef PROGMEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    assign beat = load_ready && bus.loadValid;

    // Load FSM state register; reset aborts any load in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Load FSM next state: last beat or a full bank both finish the load.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (bus.loadStart) state_d = S_LOADING;
            S_LOADING: if (beat && (bus.loadLast || ptr_q == PTR_MAX)) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Load FSM outputs are pure decodes of the state.
    always_comb begin
        load_ready = (state_q == S_LOADING);
        load_done  = (state_q == S_DONE);
    end

    // Load datapath: bank/pointer/length bookkeeping and the write port.
    // The target bank's length is held at 0 for the whole load, so fetches
    // from it return HALT and never observe a half-written program.
    always_comb begin
        cur_bank_d = cur_bank_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        wr_idx     = {cur_bank_q, ptr_q};
        wr_word    = encode(bus.loadData);
        if (state_q == S_IDLE && bus.loadStart) begin
            cur_bank_d = bus.loadBank;
            ptr_d      = '0;
            overflow_d = 1'b0;
            if (bank_ok(bus.loadBank)) len_d[bus.loadBank] = '0;
        end else if (beat) begin
            wr_en = bank_ok(cur_bank_q);
            ptr_d = ptr_q + PTR_ONE;
            if (bank_ok(cur_bank_q)) begin
                if (bus.loadLast) begin
                    len_d[cur_bank_q] = {1'b0, ptr_q} + LEN_ONE;
                end else if (ptr_q == PTR_MAX) begin
                    len_d[cur_bank_q] = LEN_FULL;
                    overflow_d        = 1'b1;
                end
            end else if (!bus.loadLast && ptr_q == PTR_MAX) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Load datapath registers; all lengths clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_bank_q <= '0;
            ptr_q      <= '0;
            overflow_q <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) len_q[b] <= '0;
        end else begin
            cur_bank_q <= cur_bank_d;
            ptr_q      <= ptr_d;
            overflow_q <= overflow_d;
            len_q      <= len_d;
        end
    end

    // Storage write port (no reset on contents).
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_word;
    end

    // Fetch lookup: out-of-range bank or address takes the HALT path.
    always_comb begin
        sel_ok  = bank_ok(bus.programSelect);
        sel_len = sel_ok ? len_q[bus.programSelect] : '0;
        hit     = sel_ok && ({1'b0, bus.fetchAddress} < sel_len);
        rd_word = mem[{bus.programSelect, bus.fetchAddress}];
    end

    // Fetch response next values; instruction holds when no fetch is issued.
    always_comb begin
        instr_valid_d = bus.fetchValid;
        instruction_d = instruction_q;
        eop_d         = 1'b0;
`ifdef PROGMEM_PARITY_EN
        perr_d        = 1'b0;
`endif
        if (bus.fetchValid) begin
            if (hit) begin
                instruction_d = rd_word[INSTR_WIDTH-1:0];
`ifdef PROGMEM_PARITY_EN
                perr_d        = ^rd_word;
`endif
            end else begin
                instruction_d = HALT_WORD;
                eop_d         = 1'b1;
            end
        end
    end

    // Fetch response registers: exactly one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid_q <= 1'b0;
            instruction_q <= '0;
            eop_q         <= 1'b0;
`ifdef PROGMEM_PARITY_EN
            perr_q        <= 1'b0;
`endif
        end else begin
            instr_valid_q <= instr_valid_d;
            instruction_q <= instruction_d;
            eop_q         <= eop_d;
`ifdef PROGMEM_PARITY_EN
            perr_q        <= perr_d;
`endif
        end
    end

    assign bus.instrValid   = instr_valid_q;
    assign bus.instruction  = instruction_q;
    assign bus.endOfProgram = eop_q;
    assign bus.bankLength   = sel_len;
    assign bus.loadReady    = load_ready;
    assign bus.loadDone     = load_done;
    assign bus.loadOverflow = overflow_q;
`ifdef PROGMEM_PARITY_EN
    assign bus.parityError  = perr_q;
`endif

endmodule

// File: tb/tb_program_memory.sv
// tb_program_memory: directed stimulus with a scoreboard for fetch responses.
// Stimulus pushes the expected fetch result; a negedge monitor pops on instrValid.
module tb_program_memory;
    localparam logic [15:0] HALT = 16'hE000;

    typedef struct {
        logic [15:0] instr;
        logic        eop;
        logic        perr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    exp_t mon_e;

    logic [15:0] exp_mem [4][256];
    int          exp_len [4];
    logic [15:0] ld_words [256];
    logic [15:0] prog_a [6];

    program_memory_if #(.INSTR_WIDTH(16), .ADDR_WIDTH(8), .NUM_BANKS(4)) pm ();

    program_memory #(
        .INSTR_WIDTH(16), .ADDR_WIDTH(8), .NUM_BANKS(4), .HALT_WORD(16'hE000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(pm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && pm.instrValid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got instrValid=1 expected no pending fetch");
            end else begin
                mon_e = sb.pop_front();
                chk("fetch_instr", pm.instruction, mon_e.instr);
                chk("fetch_eop", pm.endOfProgram, mon_e.eop);
`ifdef PROGMEM_PARITY_EN
                chk("fetch_parity", pm.parityError, mon_e.perr);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input int b, input int a, input logic [15:0] ei,
                             input logic ee, input logic ep);
        exp_t e;
        pm.programSelect = b[1:0];
        pm.fetchAddress  = a[7:0];
        pm.fetchValid    = 1'b1;
        e.instr = ei; e.eop = ee; e.perr = ep;
        sb.push_back(e);
    endtask

    task automatic set_fetch_model(input int b, input int a);
        if (a < exp_len[b]) set_fetch(b, a, exp_mem[b][a], 1'b0, 1'b0);
        else                set_fetch(b, a, HALT, 1'b1, 1'b0);
    endtask

    task automatic fetch(input int b, input int a, input logic [15:0] ei, input logic ee);
        set_fetch(b, a, ei, ee, 1'b0);
        tick();
        pm.fetchValid = 1'b0;
    endtask

    task automatic step(input int fbank, input int lbank, inout int fc);
        if (fbank >= 0) begin
            fc++;
            set_fetch_model((fc % 2) ? lbank : fbank, fc % 8);
        end
        tick();
    endtask

    task automatic do_load(input int bank, input int n, input bit last,
                           input bit gaps, input int fbank);
        int fc = 0;
        pm.loadStart = 1'b1;
        pm.loadBank  = bank[1:0];
        step(fbank, bank, fc);
        pm.loadStart = 1'b0;
        exp_len[bank] = 0;
        chk("load_ready", pm.loadReady, 1);
        chk("overflow_cleared", pm.loadOverflow, 0);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) begin
                pm.loadValid = 1'b0;
                step(fbank, bank, fc);
            end
            pm.loadValid = 1'b1;
            pm.loadData  = ld_words[i];
            pm.loadLast  = last && (i == n - 1);
            exp_mem[bank][i] = ld_words[i];
            step(fbank, bank, fc);
        end
        pm.loadValid  = 1'b0;
        pm.loadLast   = 1'b0;
        pm.fetchValid = 1'b0;
        exp_len[bank] = n;
        chk("load_done", pm.loadDone, 1);
        chk("load_ready_in_done", pm.loadReady, 0);
        chk("load_overflow", pm.loadOverflow, {31'd0, !last});
        tick();
        chk("load_done_pulse", pm.loadDone, 0);
    endtask

    // Watchdog
    initial begin
        #1000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        prog_a = '{16'h0102, 16'h2F10, 16'h0203, 16'h2F20, 16'h4F21, 16'hE000};
        for (int b = 0; b < 4; b++) exp_len[b] = 0;
        rst_n = 1'b0;
        pm.programSelect = '0; pm.fetchValid = 1'b0; pm.fetchAddress = '0;
        pm.loadStart = 1'b0; pm.loadBank = '0; pm.loadValid = 1'b0;
        pm.loadData = '0; pm.loadLast = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_instrValid", pm.instrValid, 0);
        chk("rst_instruction", pm.instruction, 0);
        chk("rst_eop", pm.endOfProgram, 0);
        chk("rst_loadReady", pm.loadReady, 0);
        chk("rst_loadDone", pm.loadDone, 0);
        chk("rst_loadOverflow", pm.loadOverflow, 0);
        chk("rst_bankLength", pm.bankLength, 0);
        rst_n = 1'b1;
        tick();

        // empty bank fetch returns HALT, valid drops after fetchValid drops
        fetch(0, 0, HALT, 1'b1);
        chk("valid_one_cycle", pm.instrValid, 1);
        tick();
        chk("valid_falls", pm.instrValid, 0);
        chk("instr_holds", pm.instruction, 32'hE000);

        // load bank 2 with six words
        for (int i = 0; i < 6; i++) ld_words[i] = prog_a[i];
        do_load(2, 6, 1'b1, 1'b0, -1);
        pm.programSelect = 2'd2;
        #1;
        chk("bank2_length", pm.bankLength, 6);
        fetch(2, 0, 16'h0102, 1'b0);
        fetch(2, 1, 16'h2F10, 1'b0);
        fetch(2, 2, 16'h0203, 1'b0);
        fetch(2, 3, 16'h2F20, 1'b0);
        fetch(2, 4, 16'h4F21, 1'b0);
        fetch(2, 5, 16'hE000, 1'b0);
        fetch(2, 6, HALT, 1'b1);
        fetch(2, 255, HALT, 1'b1);

        // gapped load into bank 3 with concurrent fetches of banks 2 and 3
        ld_words[0] = 16'h3A01; ld_words[1] = 16'h3A02;
        ld_words[2] = 16'h3A03; ld_words[3] = 16'h3A04;
        do_load(3, 4, 1'b1, 1'b1, 2);
        fetch(3, 0, 16'h3A01, 1'b0);
        fetch(3, 3, 16'h3A04, 1'b0);
        fetch(3, 4, HALT, 1'b1);
        fetch(2, 4, 16'h4F21, 1'b0);

        // overflow: fill bank 0 without loadLast
        for (int i = 0; i < 256; i++) ld_words[i] = 16'h1000 + 16'(i);
        do_load(0, 256, 1'b0, 1'b0, -1);
        chk("overflow_sticky", pm.loadOverflow, 1);
        pm.programSelect = 2'd0;
        #1;
        chk("bank0_full_length", pm.bankLength, 256);
        fetch(0, 0, 16'h1000, 1'b0);
        fetch(0, 255, 16'h10FF, 1'b0);
        ld_words[0] = 16'h7777;
        do_load(1, 1, 1'b1, 1'b0, -1);
        fetch(1, 0, 16'h7777, 1'b0);
        fetch(1, 1, HALT, 1'b1);
        repeat (2) tick();

        // reset in the middle of a load
        pm.loadStart = 1'b1; pm.loadBank = 2'd1;
        tick();
        pm.loadStart = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pm.loadValid = 1'b1; pm.loadData = 16'hBEE0 + 16'(i);
            tick();
        end
        pm.loadValid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_loadReady", pm.loadReady, 0);
        for (int b = 0; b < 4; b++) begin
            pm.programSelect = b[1:0];
            #1;
            chk("midrst_bankLength", pm.bankLength, 0);
            exp_len[b] = 0;
        end
        tick();
        rst_n = 1'b1;
        tick();
        fetch(0, 0, HALT, 1'b1);
        fetch(2, 0, HALT, 1'b1);
        fetch(1, 0, HALT, 1'b1);
        ld_words[0] = 16'h5555; ld_words[1] = 16'hAAAA;
        do_load(1, 2, 1'b1, 1'b0, -1);
        fetch(1, 0, 16'h5555, 1'b0);
        fetch(1, 1, 16'hAAAA, 1'b0);
        fetch(1, 2, HALT, 1'b1);

`ifdef PROGMEM_PARITY_EN
        // corrupt one stored bit of bank 1 address 0
        dut.mem[256] = dut.mem[256] ^ 17'h00001;
        set_fetch(1, 0, 16'h5554, 1'b0, 1'b1);
        tick();
        set_fetch(1, 1, 16'hAAAA, 1'b0, 1'b0);
        tick();
        pm.fetchValid = 1'b0;
`endif

        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/program_memory.md
# program_memory

Writable, multi-bank instruction memory for the 16-bit processor, replacing fixed compiled-in program images. Programs are streamed in over a valid/ready load port into one of `NUM_BANKS` banks while the CPU fetches from the bank chosen by `programSelect`. Fetch reads are registered with one-cycle latency. Any address past a bank's loaded length returns the HALT word, so the CPU stops cleanly on short or partially loaded programs.

## Interface
- `INSTR_WIDTH`, 16, instruction word width.
- `ADDR_WIDTH`, 8, address width; `DEPTH = 2**ADDR_WIDTH` words per bank.
- `NUM_BANKS`, 4, program bank count (≥1); `BANK_W = max(1, $clog2(NUM_BANKS))` (derived).
- `HALT_WORD`, 16'hE000, word returned for unloaded or out-of-range fetches.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `programSelect`  in  BANK_W  bank used for fetch.
- `fetchValid`  in  1  fetch request this cycle.
- `fetchAddress`  in  ADDR_WIDTH  word address of the fetch.
- `instrValid`  out  1  `instruction` valid (one cycle after `fetchValid`).
- `instruction`  out  INSTR_WIDTH  fetched word.
- `endOfProgram`  out  1  with `instrValid`: the address was ≥ bank length, so `instruction` = `HALT_WORD`.
- `bankLength`  out  ADDR_WIDTH+1  combinational loaded length of `programSelect` bank.
- `loadStart`  in  1  begin loading `loadBank` (honoured in IDLE only).
- `loadBank`  in  BANK_W  target bank, sampled on accepted `loadStart`.
- `loadValid`  in  1  `loadData` beat present.
- `loadData`  in  INSTR_WIDTH  instruction to store.
- `loadLast`  in  1  marks final beat.
- `loadReady`  out  1  high in LOADING.
- `loadDone`  out  1  one-cycle pulse on load completion.
- `loadOverflow`  out  1  sticky: a load filled the bank without `loadLast`; cleared by next accepted `loadStart` or reset.
- `parityError`  out  1  only with `PROGMEM_PARITY_EN`.

## Operation
- Per-bank length register `len[b]` (0..DEPTH). Memory contents are not reset.
- FSM states:
  - IDLE: `loadStart` → LOADING. Latch `loadBank` into `curBank`; set `ptr=0`, `len[curBank]=0`, clear `loadOverflow`.
  - LOADING: each `loadValid && loadReady` beat writes `mem[curBank][ptr]` and increments `ptr`. `loadLast` → DONE with `len = ptr+1`. A beat at `ptr==DEPTH-1` without `loadLast` → DONE with `len=DEPTH` and sets `loadOverflow`. `loadStart` is ignored here.
  - DONE: `loadDone=1`, `loadReady=0`; return to IDLE next cycle.
- `len[curBank]` stays 0 during LOADING. Fetches from the bank being loaded therefore return HALT, with no read/write hazard.
- Fetch: `instruction = (programSelect < NUM_BANKS && fetchAddress < len[programSelect]) ? mem : HALT_WORD`. `endOfProgram` is set when the HALT path is taken.
- Fetches from other banks proceed concurrently with a load.

## Timing
- Reset values: `instrValid=0`, `instruction=0`, `endOfProgram=0`, `loadReady=0`, `loadDone=0`, `loadOverflow=0`, `parityError=0`, all `len=0`, state IDLE.
- Fetch latency is exactly 1 cycle. A fetch is accepted every cycle; inputs are sampled on the `fetchValid` edge.
- `instrValid` falls the cycle after `fetchValid` falls. `instruction` holds its last value when invalid.
- `loadStart` edge → `loadReady` high next cycle. The first beat can be accepted that cycle.
- The last beat's edge → DONE: `loadDone` high for one cycle. `len` is visible to fetches from that cycle on.
- Fetch of address k from the loaded bank is valid from the cycle after the `loadDone` pulse.
- Reset mid-load: abort; all lengths become 0, so every bank reads HALT.

## Configuration
- `PROGMEM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit, computed on write.
  - On an in-length fetch, parity is rechecked. `parityError` pulses aligned with `instrValid` on mismatch.
  - HALT-path fetches never flag.
- Undefined: no parity storage, and the `parityError` port is absent.

## Test plan
- Reset, then fetch bank 0 address 0 → `instruction=16'hE000`, `endOfProgram=1`, `instrValid=1` one cycle later.
- Load bank 2 with 6 words (0x0102, 0x2F10, 0x0203, 0x2F20, 0x4F21, 0xE000), `loadLast` on the 6th → `loadDone` pulse; `bankLength=6` with `programSelect=2`; fetches of addr 0..5 return the words; addr 6 → HALT, `endOfProgram=1`.
- Load with `loadValid` gaps, and fetch bank 2 at the same time as loading bank 3 → bank 2 data correct; bank 3 fetches return HALT until `loadDone`.
- Stream `DEPTH` (256) beats without `loadLast` → `loadOverflow=1`, `len=256`, addr 255 returns the last word; the next `loadStart` clears `loadOverflow`.
- Assert `rst_n=0` after 3 beats of a load → `loadReady=0`, all lengths 0, all fetches HALT; a re-load after reset succeeds.
- With `PROGMEM_PARITY_EN`: force-flip one stored bit of bank 1 addr 0 → the fetch gives `parityError=1` for one cycle; a clean word gives 0.
